// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg
// Shared definitions for the March C- RAM BIST controller:
//   - bist_state_e   : controller FSM state encoding
//   - march_elem_t   : one march element (direction, op count, per-op
//                      read/write flag and data polarity)
//   - march_elem()   : the March C- element table, indexed 0..5
//   - op cycle-count constants for write (3) and read (4) operations
package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } bist_state_e;

  // Bus cycles spent on one write / one read operation.
  localparam logic [2:0] WRITE_OP_CYCLES = 3'd3;
  localparam logic [2:0] READ_OP_CYCLES  = 3'd4;

  // Index of the final march element.
  localparam logic [2:0] LAST_ELEM = 3'd5;

  // Bit i of op_rd / op_one describes op i of the element:
  // op_rd=1 -> read (compare), op_rd=0 -> write; op_one=1 -> all-ones word.
  typedef struct packed {
    logic       down;
    logic [1:0] op_cnt;
    logic [1:0] op_rd;
    logic [1:0] op_one;
  } march_elem_t;

  // March C-: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0)
  function automatic march_elem_t march_elem(input logic [2:0] idx);
    march_elem_t e;
    case (idx)
      3'd0:    e = '{down: 1'b0, op_cnt: 2'd1, op_rd: 2'b00, op_one: 2'b00};
      3'd1:    e = '{down: 1'b0, op_cnt: 2'd2, op_rd: 2'b01, op_one: 2'b10};
      3'd2:    e = '{down: 1'b0, op_cnt: 2'd2, op_rd: 2'b01, op_one: 2'b01};
      3'd3:    e = '{down: 1'b1, op_cnt: 2'd2, op_rd: 2'b01, op_one: 2'b10};
      3'd4:    e = '{down: 1'b1, op_cnt: 2'd2, op_rd: 2'b01, op_one: 2'b01};
      3'd5:    e = '{down: 1'b0, op_cnt: 2'd1, op_rd: 2'b01, op_one: 2'b00};
      default: e = '{down: 1'b0, op_cnt: 2'd1, op_rd: 2'b00, op_one: 2'b00};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen
// Up/down address counter for the march sequencer.
//   clk_i, rst_i  : clock, asynchronous active-high reset (address -> 0)
//   load_i        : load the start address of an element (priority over en_i)
//   load_down_i   : direction of the element being loaded (1 -> all-ones)
//   down_i        : direction of the current element (step and terminal count)
//   en_i          : step one address in direction down_i, wrapping modulo 2^AW
//   addr_o        : current address
//   tc_o          : current address is the last one of the current element
module ram_bist_addr_gen #(
  parameter int AW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          load_down_i,
  input  logic          down_i,
  input  logic          en_i,
  output logic [AW-1:0] addr_o,
  output logic          tc_o
);

  localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  // Next address: load start point, step, or hold.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? ADDR_MAX : ADDR_ZERO;
    end else if (en_i) begin
      addr_d = down_i ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= ADDR_ZERO;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign tc_o   = down_i ? (addr_q == ADDR_ZERO) : (addr_q == ADDR_MAX);

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
// March C- BIST controller for a small synchronous-strobe RAM.
// Ports:
//   CLK, RST            : clock, asynchronous active-high reset
//   START               : level, sampled in IDLE, launches one run
//   ADDRESS, DATA       : RAM address / write-data bus
//   CS, WE, OE          : RAM chip select, write enable, output enable
//   RAM_OUT             : RAM read data (meaningful only with CS and OE)
//   BUSY, DONE          : run in progress / one-cycle end-of-run pulse
//   FAIL                : sticky miscompare flag, cleared by next START
//   FAIL_ADDR/EXP/GOT   : log of the first miscompare in the run
// Configuration macro: RAM_BIST_STOP_ON_FAIL_EN -- when defined, the first
// miscompare ends the run (HOLD -> DONE) instead of completing all elements.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int Address_size = 2,
  parameter int Word_size    = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic [Address_size-1:0] ADDRESS,
  output logic [Word_size-1:0]    DATA,
  output logic                    CS,
  output logic                    WE,
  output logic                    OE,
  input  logic [Word_size-1:0]    RAM_OUT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [Address_size-1:0] FAIL_ADDR,
  output logic [Word_size-1:0]    FAIL_EXP,
  output logic [Word_size-1:0]    FAIL_GOT
);

  bist_state_e state_q, state_d;
  logic [2:0]  elem_q, elem_d;
  logic        op_q, op_d;

  logic                    fail_q;
  logic [Address_size-1:0] fail_addr_q;
  logic [Word_size-1:0]    fail_exp_q;
  logic [Word_size-1:0]    fail_got_q;

  logic                    ag_load;
  logic                    ag_load_down;
  logic                    ag_en;
  logic [Address_size-1:0] addr;
  logic                    addr_tc;

  march_elem_t             cur_elem;
  march_elem_t             nxt_elem;
  logic                    cur_rd;
  logic                    cur_one;
  logic [Word_size-1:0]    cur_word;
  logic [2:0]              op_len;
  logic                    last_op;
  logic                    stop_on_fail;

  assign cur_elem = march_elem(elem_q);
  assign nxt_elem = march_elem(elem_q + 3'd1);
  assign cur_rd   = cur_elem.op_rd[op_q];
  assign cur_one  = cur_elem.op_one[op_q];
  assign cur_word = cur_one ? {Word_size{1'b1}} : {Word_size{1'b0}};
  assign op_len   = cur_rd ? READ_OP_CYCLES : WRITE_OP_CYCLES;
  assign last_op  = ({1'b0, op_q} == (cur_elem.op_cnt - 2'd1));

`ifdef RAM_BIST_STOP_ON_FAIL_EN
  assign stop_on_fail = fail_q;
`else
  assign stop_on_fail = 1'b0;
`endif

  ram_bist_addr_gen #(
    .AW (Address_size)
  ) u_addr_gen (
    .clk_i       (CLK),
    .rst_i       (RST),
    .load_i      (ag_load),
    .load_down_i (ag_load_down),
    .down_i      (cur_elem.down),
    .en_i        (ag_en),
    .addr_o      (addr),
    .tc_o        (addr_tc)
  );

  // FSM state and march position registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      elem_q  <= 3'd0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic: op phases, then op -> address -> element sequencing.
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    op_d         = op_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d      = ST_SETUP;
          elem_d       = 3'd0;
          op_d         = 1'b0;
          ag_load      = 1'b1;
          ag_load_down = march_elem(3'd0).down;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP:  state_d = ST_STROBE;
      // Writes skip the sample phase.
      ST_STROBE: state_d = (op_len == WRITE_OP_CYCLES) ? ST_HOLD : ST_SAMPLE;
      ST_SAMPLE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (stop_on_fail) begin
          state_d = ST_DONE;
        end else if (!last_op) begin
          state_d = ST_SETUP;
          op_d    = 1'b1;
        end else if (!addr_tc) begin
          state_d = ST_SETUP;
          op_d    = 1'b0;
          ag_en   = 1'b1;
        end else if (elem_q != LAST_ELEM) begin
          // Next element starts at its own end of the address range.
          state_d      = ST_SETUP;
          elem_d       = elem_q + 3'd1;
          op_d         = 1'b0;
          ag_load      = 1'b1;
          ag_load_down = nxt_elem.down;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // First-failure log: cleared on an accepted START, loaded once per run.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fail_q      <= 1'b0;
      fail_addr_q <= {Address_size{1'b0}};
      fail_exp_q  <= {Word_size{1'b0}};
      fail_got_q  <= {Word_size{1'b0}};
    end else if ((state_q == ST_IDLE) && START) begin
      fail_q      <= 1'b0;
      fail_addr_q <= {Address_size{1'b0}};
      fail_exp_q  <= {Word_size{1'b0}};
      fail_got_q  <= {Word_size{1'b0}};
    end else if ((state_q == ST_SAMPLE) && (RAM_OUT != cur_word) && !fail_q) begin
      fail_q      <= 1'b1;
      fail_addr_q <= addr;
      fail_exp_q  <= cur_word;
      fail_got_q  <= RAM_OUT;
    end
  end

  // Output decode: bus held constant from SETUP through HOLD of each op.
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    CS   = 1'b0;
    OE   = 1'b0;
    WE   = 1'b0;
    DATA = {Word_size{1'b0}};
    case (state_q)
      ST_IDLE: begin
        BUSY = 1'b0;
      end
      ST_SETUP, ST_HOLD: begin
        BUSY = 1'b1;
        WE   = !cur_rd;
        DATA = cur_word;
      end
      ST_STROBE: begin
        BUSY = 1'b1;
        CS   = 1'b1;
        WE   = !cur_rd;
        DATA = cur_word;
      end
      ST_SAMPLE: begin
        BUSY = 1'b1;
        CS   = 1'b1;
        OE   = 1'b1;
        WE   = 1'b0;
        DATA = cur_word;
      end
      ST_DONE: begin
        DONE = 1'b1;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  assign ADDRESS   = addr;
  assign FAIL      = fail_q;
  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_EXP  = fail_exp_q;
  assign FAIL_GOT  = fail_got_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl
// Scoreboard bench for ram_bist_ctrl: each accepted START pushes the expected
// run result (busy length, fail flag, failure log); a monitor pops and checks
// on every DONE pulse and watches the RAM bus protocol every cycle.
module tb_ram_bist_ctrl;

  localparam int AW = 2;
  localparam int WW = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [AW-1:0] ADDRESS;
  logic [WW-1:0] DATA;
  logic          CS, WE, OE;
  logic [WW-1:0] RAM_OUT;
  logic          BUSY, DONE, FAIL;
  logic [AW-1:0] FAIL_ADDR;
  logic [WW-1:0] FAIL_EXP, FAIL_GOT;

  ram_bist_ctrl #(.Address_size(AW), .Word_size(WW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ADDRESS(ADDRESS), .DATA(DATA),
    .CS(CS), .WE(WE), .OE(OE), .RAM_OUT(RAM_OUT), .BUSY(BUSY), .DONE(DONE),
    .FAIL(FAIL), .FAIL_ADDR(FAIL_ADDR), .FAIL_EXP(FAIL_EXP), .FAIL_GOT(FAIL_GOT)
  );

  always #5 CLK = ~CLK;

  // RAM model; fault_en makes bit 0 of address 2 stuck at 0.
  logic [WW-1:0] mem [0:3];
  logic          fault_en;
  always @(posedge CLK) begin
    if (!RST && CS && WE)
      mem[ADDRESS] <= (fault_en && ADDRESS == 2'b10) ? (DATA & 3'b110) : DATA;
  end
  always_comb RAM_OUT = (CS && OE) ? mem[ADDRESS] : 3'b000;

  typedef struct {
    int          cycles;
    logic        fail;
    logic [1:0]  fa;
    logic [2:0]  fe;
    logic [2:0]  fg;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  logic prev_cs = 1'b0;
  logic [5:0] bus_cap = 6'd0;

`ifdef RAM_BIST_STOP_ON_FAIL_EN
  localparam int FAULT_CYCLES = 58;
`else
  localparam int FAULT_CYCLES = 140;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on DONE.
  always @(negedge CLK) begin
    if (RST) begin
      busy_cnt = 0;
      prev_cs  = 1'b0;
    end else begin
      if (BUSY) busy_cnt++;
      chk("we_and_oe", {31'd0, WE && OE}, 32'd0);
      chk("oe_without_cs", {31'd0, OE && !CS}, 32'd0);
      if (CS && !prev_cs) bus_cap = {ADDRESS, DATA, WE};
      else if (prev_cs) chk("bus_stable", {26'd0, ADDRESS, DATA, WE}, {26'd0, bus_cap});
      prev_cs = CS;
      if (DONE) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done got=DONE expected=no DONE");
        end else begin
          mon_e = sb_q.pop_front();
          chk("busy_cycles", busy_cnt, mon_e.cycles);
          chk("busy_at_done", {31'd0, BUSY}, 32'd0);
          chk("fail_flag", {31'd0, FAIL}, {31'd0, mon_e.fail});
          chk("fail_addr", {30'd0, FAIL_ADDR}, {30'd0, mon_e.fa});
          chk("fail_exp", {29'd0, FAIL_EXP}, {29'd0, mon_e.fe});
          chk("fail_got", {29'd0, FAIL_GOT}, {29'd0, mon_e.fg});
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic push_exp(input int cyc, input logic f, input logic [1:0] fa,
                          input logic [2:0] fe, input logic [2:0] fg);
    exp_t e;
    e.cycles = cyc; e.fail = f; e.fa = fa; e.fe = fe; e.fg = fg;
    sb_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK); #1;
      if (done_cnt >= n) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout got=%0d expected=%0d", done_cnt, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    chk({tag, "_done"}, {31'd0, DONE}, 32'd0);
    chk({tag, "_fail"}, {31'd0, FAIL}, 32'd0);
    chk({tag, "_cs_we_oe"}, {29'd0, CS, WE, OE}, 32'd0);
    chk({tag, "_addr_data"}, {27'd0, ADDRESS, DATA}, 32'd0);
    chk({tag, "_log"}, {24'd0, FAIL_ADDR, FAIL_EXP, FAIL_GOT}, 32'd0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; fault_en = 1'b0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Run 1: fault-free, with a stray START mid-run that must be ignored.
    push_exp(140, 1'b0, 2'b00, 3'b000, 3'b000);
    pulse_start();
    chk("busy_after_start", {31'd0, BUSY}, 32'd1);
    repeat (20) @(posedge CLK);
    #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    wait_done(1);

    // Run 2: stuck-at-0 on bit 0 of address 2.
    fault_en = 1'b1;
    push_exp(FAULT_CYCLES, 1'b1, 2'b10, 3'b111, 3'b110);
    pulse_start();
    wait_done(2);
    repeat (3) @(posedge CLK);
    #1 chk("fail_sticky_idle", {31'd0, FAIL}, 32'd1);

    // Run 3: aborted by reset around cycle 50.
    fault_en = 1'b0;
    pulse_start();
    chk("fail_cleared_by_start", {31'd0, FAIL}, 32'd0);
    repeat (48) @(posedge CLK);
    #2 RST = 1'b1;
    #1 chk_all_zero("async_rst");
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1 chk("idle_after_rst", {31'd0, BUSY}, 32'd0);

    // Run 4: full clean run after reset.
    push_exp(140, 1'b0, 2'b00, 3'b000, 3'b000);
    pulse_start();
    wait_done(3);

    // Runs 5/6: START held across DONE relaunches from IDLE.
    push_exp(140, 1'b0, 2'b00, 3'b000, 3'b000);
    push_exp(140, 1'b0, 2'b00, 3'b000, 3'b000);
    @(posedge CLK); #1 START = 1'b1;
    wait_done(4);
    @(posedge CLK);
    @(posedge CLK);
    #1 START = 1'b0;
    chk("relaunch_busy", {31'd0, BUSY}, 32'd1);
    wait_done(5);

    repeat (20) @(posedge CLK);
    #1;
    chk("done_count", done_cnt, 32'd5);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
